// File: rtl/uart_bfm_chan.sv
// rtl/uart_bfm_chan.sv - parametrised UART stimulus/capture channel with TX/RX FIFOs
module uart_bfm_fifo #(
    parameter int W    = 8,
    parameter int LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [LOG2:0] level
);
    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem_q [DEPTH];
    logic [LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]   level_q, level_d;
    logic            rd_ok, wr_ok;

    // A write into a full FIFO is still taken when a pop frees the slot in the same cycle.
    always_comb begin
        rd_ok    = rd_en && (level_q != '0);
        wr_ok    = wr_en && (!level_q[LOG2] || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            level_d = level_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
endmodule

module uart_bfm_chan #(
    parameter int DIV       = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_idle,
    input  logic                 cts_n,
    output logic                 uart_txd,
    input  logic                 uart_rxd,
    output logic [7:0]           rx_data,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    output logic [FIFO_LOG2:0]   rx_level,
    input  logic                 err_clr,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_ovf,
    output logic                 tx_drop
);
    localparam int              CW        = $clog2(2 * DIV + 1);
    localparam logic [CW-1:0]   BIT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0]   STOP_END  = CW'(STOP_BITS * DIV - 1);
    localparam logic [CW-1:0]   HALF_END  = CW'(DIV / 2 - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

    logic [7:0]         tx_head, rx_head;
    logic [FIFO_LOG2:0] tx_level;
    logic               tx_empty, tx_go, tx_pop, tx_par_bit;
    logic               rx_full, rx_push, set_perr, set_ferr, set_ovf, set_drop;

    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_par_q, tx_par_d;
    logic          txd_q, txd_d;

    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_pbad_q, rx_pbad_d;
    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

    logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d, drop_q, drop_d;

    uart_bfm_fifo #(.W(8), .LOG2(FIFO_LOG2)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .wr_en(tx_wr), .wr_data(tx_data & DATA_MASK),
        .rd_en(tx_pop), .rd_data(tx_head), .level(tx_level)
    );

    uart_bfm_fifo #(.W(8), .LOG2(FIFO_LOG2)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .wr_en(rx_push), .wr_data(rx_shift_q),
        .rd_en(rx_rd), .rd_data(rx_head), .level(rx_level)
    );

    assign tx_empty = (tx_level == '0);
    assign tx_full  = tx_level[FIFO_LOG2];
    assign tx_idle  = tx_empty && (tx_state_q == ST_IDLE);
    assign uart_txd = txd_q;
    assign rx_full  = rx_level[FIFO_LOG2];
    assign rx_empty = (rx_level == '0);
    assign rx_data  = rx_empty ? 8'h00 : rx_head;
    assign rx_perr  = perr_q;
    assign rx_ferr  = ferr_q;
    assign rx_ovf   = ovf_q;
    assign tx_drop  = drop_q;

    // The end of the stop bit doubles as an IDLE decision so back-to-back frames have no gap.
    always_comb begin
        tx_go      = !tx_empty && !cts_n;
        tx_pop     = tx_go && ((tx_state_q == ST_IDLE) ||
                               ((tx_state_q == ST_STOP) && (tx_cnt_q == STOP_END)));
        tx_par_bit = (PARITY == 1) ? ~(^tx_head) : (^tx_head);
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        case (tx_state_q)
            ST_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    txd_d      = tx_shift_q[1];
                    if (tx_bit_q == LAST_BIT) begin
                        tx_bit_d = '0;
                        if (PARITY != 0) begin
                            tx_state_d = ST_PAR;
                            txd_d      = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            txd_d      = 1'b1;
                        end
                    end
                end
            end
            ST_PAR: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_state_d = ST_STOP;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == STOP_END) begin
                    tx_state_d = ST_IDLE;
                    tx_cnt_d   = '0;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_cnt_d   = '0;
                txd_d      = 1'b1;
            end
        endcase
        if (tx_pop) begin
            tx_state_d = ST_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_head;
            tx_par_d   = tx_par_bit;
            txd_d      = 1'b0;
        end
    end

    // Start detection needs a falling edge, so a stuck-low line cannot re-arm a frame.
    always_comb begin
        rx_s1_d    = uart_rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_pbad_d  = rx_pbad_q;
        rx_push    = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        case (rx_state_q)
            ST_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_shift_d = '0;
                    rx_pbad_d  = 1'b0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d             = '0;
                    rx_bit_d             = rx_bit_q + 1'b1;
                    rx_shift_d           = rx_shift_q >> 1;
                    rx_shift_d[LAST_BIT] = rx_s2_q;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_STOP;
                    rx_pbad_d  = (PARITY == 1) ? ~(^rx_shift_q ^ rx_s2_q) : (^rx_shift_q ^ rx_s2_q);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    rx_push    = 1'b1;
                    set_ferr   = !rx_s2_q;
                    set_perr   = rx_pbad_q;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
                rx_cnt_d   = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = ST_START;
                end
            end
        endcase
    end

    always_comb begin
        set_ovf  = rx_push && rx_full && !rx_rd;
        set_drop = tx_wr && tx_full && !tx_pop;
        perr_d   = (perr_q && !err_clr) || set_perr;
        ferr_d   = (ferr_q && !err_clr) || set_ferr;
        ovf_d    = (ovf_q  && !err_clr) || set_ovf;
        drop_d   = (drop_q && !err_clr) || set_drop;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_pbad_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_pbad_q  <= rx_pbad_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end
endmodule

// File: tb/tb_uart_bfm_chan.sv
// tb/tb_uart_bfm_chan.sv - self-checking bench for uart_bfm_chan
module tb_uart_bfm_chan;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0: 8N1 looped back, 1: 8E1 looped back (or injected), 2: 8O2 driven by the bench
    logic [7:0] tx_data [3];
    logic       tx_wr [3], tx_full [3], tx_idle [3], cts_n [3], txd [3], rxd [3];
    logic [7:0] rx_data [3];
    logic       rx_rd [3], rx_empty [3], err_clr [3];
    logic [4:0] rx_level [3];
    logic       perr [3], ferr [3], ovf [3], drop [3];
    logic       line [3];
    logic       e_inj;

    assign rxd[0] = txd[0];
    assign rxd[1] = e_inj ? line[1] : txd[1];
    assign rxd[2] = line[2];

    uart_bfm_chan #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_LOG2(4)) dut_n (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data(tx_data[0]), .tx_wr(tx_wr[0]),
        .tx_full(tx_full[0]), .tx_idle(tx_idle[0]), .cts_n(cts_n[0]), .uart_txd(txd[0]),
        .uart_rxd(rxd[0]), .rx_data(rx_data[0]), .rx_rd(rx_rd[0]), .rx_empty(rx_empty[0]),
        .rx_level(rx_level[0]), .err_clr(err_clr[0]), .rx_perr(perr[0]), .rx_ferr(ferr[0]),
        .rx_ovf(ovf[0]), .tx_drop(drop[0]));

    uart_bfm_chan #(.DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_LOG2(4)) dut_e (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data(tx_data[1]), .tx_wr(tx_wr[1]),
        .tx_full(tx_full[1]), .tx_idle(tx_idle[1]), .cts_n(cts_n[1]), .uart_txd(txd[1]),
        .uart_rxd(rxd[1]), .rx_data(rx_data[1]), .rx_rd(rx_rd[1]), .rx_empty(rx_empty[1]),
        .rx_level(rx_level[1]), .err_clr(err_clr[1]), .rx_perr(perr[1]), .rx_ferr(ferr[1]),
        .rx_ovf(ovf[1]), .tx_drop(drop[1]));

    uart_bfm_chan #(.DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_LOG2(4)) dut_o (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_data(tx_data[2]), .tx_wr(tx_wr[2]),
        .tx_full(tx_full[2]), .tx_idle(tx_idle[2]), .cts_n(cts_n[2]), .uart_txd(txd[2]),
        .uart_rxd(rxd[2]), .rx_data(rx_data[2]), .rx_rd(rx_rd[2]), .rx_empty(rx_empty[2]),
        .rx_level(rx_level[2]), .err_clr(err_clr[2]), .rx_perr(perr[2]), .rx_ferr(ferr[2]),
        .rx_ovf(ovf[2]), .tx_drop(drop[2]));

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] d;
        logic       par;
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input int s, input logic [7:0] d);
        tx_data[s] = d;
        tx_wr[s]   = 1'b1;
        tick();
        tx_wr[s]   = 1'b0;
    endtask

    task automatic pop_check(input int s, input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            check(tag, rx_data[s], exp);
        end
        rx_rd[s] = 1'b1;
        tick();
        rx_rd[s] = 1'b0;
    endtask

    task automatic clear_errs(input int s);
        err_clr[s] = 1'b1;
        tick();
        err_clr[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s, input int max, input string tag);
        int i = 0;
        while (!tx_idle[s] && i < max) begin
            tick();
            i++;
        end
        check(tag, tx_idle[s], 1);
    endtask

    // Writes one byte and checks every cycle of the serial frame from the pop edge onwards.
    task automatic tx_wave(input int s, input logic [7:0] d, input bit has_par, input bit par,
                           input int nstop, input string tag);
        logic [15:0] frame;
        int nbits;
        nbits = 9 + (has_par ? 1 : 0) + nstop;
        frame = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1 + i] = d[i];
        if (has_par) frame[9] = par;
        write_byte(s, d);
        tick();
        for (int k = 0; k < nbits * DIV; k++) begin
            check($sformatf("%s_c%0d", tag, k), txd[s], frame[k / DIV]);
            if (k == nbits * DIV - 1) check({tag, "_busy_last"}, tx_idle[s], 0);
            tick();
        end
        check({tag, "_idle_end"}, tx_idle[s], 1);
        check({tag, "_txd_end"}, txd[s], 1);
    endtask

    task automatic send_line(input int s, input logic [7:0] d, input bit par, input bit stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            line[s] = bits[b];
            repeat (DIV) tick();
        end
        line[s] = 1'b1;
        repeat (2 * DIV) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen_low;
        for (int s = 0; s < 3; s++) begin
            tx_data[s] = 8'h00; tx_wr[s] = 1'b0; cts_n[s] = 1'b0;
            rx_rd[s] = 1'b0; err_clr[s] = 1'b0; line[s] = 1'b1;
        end
        e_inj = 1'b0;
        vecs[0] = '{8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b0};
        vecs[2] = '{8'hA5, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h7F, 1'b1};

        repeat (3) tick();
        check("rst_txd", txd[1], 1);
        check("rst_tx_full", tx_full[1], 0);
        check("rst_tx_idle", tx_idle[1], 1);
        check("rst_rx_empty", rx_empty[1], 1);
        check("rst_rx_level", rx_level[1], 0);
        check("rst_rx_data", rx_data[1], 0);
        check("rst_flags", {perr[1], ferr[1], ovf[1], drop[1]}, 0);
        rst = 1'b0;
        tick();

        tx_wave(0, 8'h55, 1'b0, 1'b0, 1, "n55");
        repeat (6) tick();
        sb.push_back(8'h55);
        check("n_rx_level", rx_level[0], 1);
        pop_check(0, "n_rx_data");
        check("n_rx_empty", rx_empty[0], 1);

        tx_wave(2, 8'h55, 1'b1, 1'b1, 2, "o55");

        for (int i = 0; i < 5; i++) begin
            sb.push_back(vecs[i].d);
            tx_wave(1, vecs[i].d, 1'b1, vecs[i].par, 1, $sformatf("e_tbl%0d", i));
            repeat (6) tick();
        end
        check("e_tbl_level", rx_level[1], 5);
        for (int i = 0; i < 5; i++) pop_check(1, $sformatf("e_tbl_rx%0d", i));
        check("e_tbl_perr", perr[1], 0);
        check("e_tbl_ferr", ferr[1], 0);
        check("e_tbl_empty", rx_empty[1], 1);

        sb.push_back(8'h3C);
        send_line(2, 8'h3C, 1'b1, 1'b0);
        check("o_ferr_only_f", ferr[2], 1);
        check("o_ferr_only_p", perr[2], 0);
        sb.push_back(8'h96);
        send_line(2, 8'h96, 1'b0, 1'b1);
        check("o_err_level", rx_level[2], 2);
        check("o_err_ferr", ferr[2], 1);
        check("o_err_perr", perr[2], 1);
        pop_check(2, "o_err_rx0");
        pop_check(2, "o_err_rx1");
        clear_errs(2);
        check("o_clr_ferr", ferr[2], 0);
        check("o_clr_perr", perr[2], 0);

        line[2] = 1'b0;
        repeat (80) tick();
        check("o_break_level", rx_level[2], 1);
        check("o_break_ferr", ferr[2], 1);
        sb.push_back(8'h00);
        pop_check(2, "o_break_rx");
        line[2] = 1'b1;
        repeat (8) tick();
        check("o_break_after", rx_level[2], 0);
        clear_errs(2);

        e_inj = 1'b1;
        repeat (4) tick();
        line[1] = 1'b0;
        tick();
        line[1] = 1'b1;
        repeat (12) tick();
        check("e_glitch_level", rx_level[1], 0);
        check("e_glitch_empty", rx_empty[1], 1);
        e_inj = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back(8'(i * 37 + 5));
            write_byte(1, 8'(i * 37 + 5));
        end
        check("e_ovf_nodrop", drop[1], 0);
        wait_idle(1, 1200, "e_ovf_idle");
        repeat (10) tick();
        check("e_ovf_level", rx_level[1], 16);
        check("e_ovf_flag", ovf[1], 1);
        for (int i = 0; i < 16; i++) pop_check(1, $sformatf("e_ovf_rx%0d", i));
        clear_errs(1);
        check("e_ovf_clr", ovf[1], 0);

        cts_n[1] = 1'b1;
        sb.push_back(8'hC3);
        sb.push_back(8'h3A);
        write_byte(1, 8'hC3);
        write_byte(1, 8'h3A);
        seen_low = 1'b0;
        repeat (20) begin
            if (!txd[1]) seen_low = 1'b1;
            tick();
        end
        check("cts_hold_txd", seen_low, 0);
        check("cts_hold_idle", tx_idle[1], 0);
        cts_n[1] = 1'b0;
        tick();
        check("cts_release_start", txd[1], 0);
        cts_n[1] = 1'b1;
        repeat (50) tick();
        seen_low = 1'b0;
        repeat (30) begin
            if (!txd[1]) seen_low = 1'b1;
            tick();
        end
        check("cts_one_frame_txd", seen_low, 0);
        check("cts_one_frame_idle", tx_idle[1], 0);
        check("cts_one_frame_level", rx_level[1], 1);
        cts_n[1] = 1'b0;
        wait_idle(1, 200, "cts_second_idle");
        repeat (10) tick();
        check("cts_level", rx_level[1], 2);
        pop_check(1, "cts_rx0");
        pop_check(1, "cts_rx1");

        cts_n[1] = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(1, 8'(i));
        check("drop_full", tx_full[1], 1);
        check("drop_before", drop[1], 0);
        write_byte(1, 8'hEE);
        check("drop_set", drop[1], 1);

        cts_n[1] = 1'b0;
        tick();
        check("rst_mid_pre", txd[1], 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_txd", txd[1], 1);
        check("rst_mid_idle", tx_idle[1], 1);
        check("rst_mid_full", tx_full[1], 0);
        check("rst_mid_drop", drop[1], 0);
        tick();
        rst = 1'b0;
        seen_low = 1'b0;
        repeat (10) begin
            if (!txd[1]) seen_low = 1'b1;
            tick();
        end
        check("rst_mid_quiet", seen_low, 0);
        check("rst_mid_level", rx_level[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
